// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature encoder: phase codes, FSM states,
// step directions and the phase-to-channel mapping.
package quad_pkg;

  // FSM states of the encoder
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Phase index for each channel pattern, named by their {A,B} value.
  // Counting the phase up walks AB through 00, 10, 11, 01.
  localparam logic [1:0] PH_00 = 2'd0;
  localparam logic [1:0] PH_10 = 2'd1;
  localparam logic [1:0] PH_11 = 2'd2;
  localparam logic [1:0] PH_01 = 2'd3;

  // Direction as a 2-bit two's complement increment (+1 / -1 mod 4)
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b11;

  // Map a phase index to the {A,B} channel pair
  function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
    return {ph[1] ^ ph[0], ph[1]};
  endfunction

endpackage

// File: rtl/quad_edge_timer.sv
// Edge pacing timer: latches a clamped period on load and issues a one-cycle
// tick every 'period' enabled cycles.
module quad_edge_timer #(
  parameter int PER_W      = 16,
  parameter int PERIOD_MIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PER_W-1:0] period_i,
  input  logic             enable_i,
  output logic             tick_o
);

  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] cnt_q, cnt_d;

  // Expiry when the counter reaches per-1 while running
  assign tick_o = enable_i && !load_i && (cnt_q == per_q - PER_W'(1));

  // Next-state: load clamps the period and clears the count
  always_comb begin
    per_d = per_q;
    cnt_d = cnt_q;
    if (load_i) begin
      per_d = (period_i < PER_W'(PERIOD_MIN)) ? PER_W'(PERIOD_MIN) : period_i;
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PER_W'(1);
    end
  end

  // Timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      per_q <= PER_W'(PERIOD_MIN);
      cnt_q <= '0;
    end else begin
      per_q <= per_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_encoder.sv
// Quadrature waveform generator: executes signed relative moves as A/B edges
// at a programmable spacing and tracks the absolute position.
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only while idle and cmd_steps/cmd_period are sampled then.
module quad_encoder
  import quad_pkg::*;
#(
  parameter int STEP_W     = 32,
  parameter int PER_W      = 16,
  parameter int PERIOD_MIN = 4,
  parameter int POS_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [STEP_W-1:0] cmd_steps,
  input  logic [PER_W-1:0]        cmd_period,
  input  logic                    abort,
  output logic                    quadA,
  output logic                    quadB,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position,
  output logic [1:0]              dbg_state_o
);

  state_t                  state_q;
  logic [1:0]              phase_q;
  logic [1:0]              dir_q;
  logic [STEP_W-1:0]       remaining_q;
  logic signed [POS_W-1:0] position_q;
  logic                    quad_a_q, quad_b_q;
  logic                    busy_q, done_q, cmd_ready_q;

  logic              accept;
  logic              tick;
  logic [STEP_W-1:0] cmd_mag;
  logic [1:0]        phase_step;

  assign accept = cmd_valid && cmd_ready_q && (state_q == IDLE);

  // Magnitude of the move; the most-negative value yields 2^(STEP_W-1)
  assign cmd_mag = cmd_steps[STEP_W-1] ? $unsigned(-cmd_steps) : $unsigned(cmd_steps);

  // Phase after one step in the latched direction (wraps mod 4)
  assign phase_step = phase_q + dir_q;

  quad_edge_timer #(
    .PER_W      (PER_W),
    .PERIOD_MIN (PERIOD_MIN)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .period_i (cmd_period),
    .enable_i (state_q == RUN),
    .tick_o   (tick)
  );

  // Control FSM with registered phase, channel, counter and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= PH_00;
      dir_q       <= DIR_UP;
      remaining_q <= '0;
      position_q  <= '0;
      quad_a_q    <= 1'b0;
      quad_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      // done and cmd_ready follow the state one cycle later
      done_q      <= (state_q == DONE);
      cmd_ready_q <= (state_q == IDLE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            dir_q       <= cmd_steps[STEP_W-1] ? DIR_DOWN : DIR_UP;
            remaining_q <= cmd_mag;
            cmd_ready_q <= 1'b0;
            if (cmd_mag == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            // abort beats a coinciding timer expiry
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            phase_q                <= phase_step;
            {quad_a_q, quad_b_q}   <= phase_to_ab(phase_step);
            position_q             <= position_q + {{(POS_W-2){dir_q[1]}}, dir_q};
            remaining_q            <= remaining_q - STEP_W'(1);
            if (remaining_q == STEP_W'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quadA       = quad_a_q;
  assign quadB       = quad_b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cmd_ready   = cmd_ready_q;
  assign position    = position_q;
  assign dbg_state_o = state_q;

endmodule
